// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-fetch controller.
//   XLEN       : datapath / address width
//   TAG_W      : width of the word-address tag (address bits [XLEN-1:2])
//   NOP_INSTR  : instruction word returned while fetch is stalled
//   fetch_state_t : fetch FSM state (IDLE, WAIT)
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = XLEN - 2;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// One-entry instruction fetch buffer: valid bit, word tag and data word, with
// a combinational hit compare against the current lookup tag.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_wr_en        : write {valid, tag, data} on the next edge
//   i_wr_tag       : word tag (address bits [XLEN-1:2]) to write
//   i_wr_data      : instruction word to write
//   i_inv          : clear valid on the next edge; wins over i_wr_en
//   i_lookup_tag   : word tag of the current fetch address
//   o_hit          : buffer valid and tag matches
//   o_data         : buffered instruction word
// -----------------------------------------------------------------------------
module fetch_buf
   import imem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic [XLEN-1:0]  i_wr_data,
   input  logic             i_inv,
   input  logic [TAG_W-1:0] i_lookup_tag,
   output logic             o_hit,
   output logic [XLEN-1:0]  o_data
);

   logic             r_valid;
   logic [TAG_W-1:0] r_tag;
   logic [XLEN-1:0]  r_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else begin
         if (i_wr_en) begin
            r_valid <= 1'b1;
            r_tag   <= i_wr_tag;
            r_data  <= i_wr_data;
         end
         // Invalidate overrides a same-edge fill; tag/data still update.
         if (i_inv) begin
            r_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      o_hit  = r_valid && (r_tag == i_lookup_tag);
      o_data = r_data;
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Instruction fetch controller: serves pc_i from a one-entry fetch buffer, and
// on a miss issues a single outstanding word read on the memory bus. Read data
// is forwarded to instr_o in the response cycle when it still matches pc_i.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   pc_i          : fetch address (held by the fetch stage while stalled)
//   inv_i         : invalidate the fetch buffer (fence.i)
//   instr_o       : instruction for pc_i, valid when stall_o=0
//   stall_o       : fetch stall
//   mem_req_o     : bus request
//   mem_addr_o    : bus word address
//   mem_gnt_i     : request accepted this cycle
//   mem_rvalid_i  : read data valid
//   mem_rdata_i   : read data
//   miss_cnt_o    : count of accepted bus requests (wraps)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
   import imem_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   input  logic            inv_i,
   output logic [XLEN-1:0] instr_o,
   output logic            stall_o,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic [XLEN-1:0] miss_cnt_o
);

   fetch_state_t     r_state;
   logic [TAG_W-1:0] r_req_tag;
   logic [XLEN-1:0]  r_miss_cnt;

   logic [TAG_W-1:0] w_pc_tag;
   logic             w_pc_unused;
   logic             w_buf_hit;
   logic [XLEN-1:0]  w_buf_data;
   logic             w_hit;
   logic             w_bypass;
   logic             w_buf_wr;
   logic             w_req;

   // Byte offset plays no part in a word fetch.
   assign w_pc_tag    = pc_i[XLEN-1:2];
   assign w_pc_unused = ^pc_i[1:0];

   fetch_buf u_fetch_buf (
      .clk          (clk),
      .rst          (rst),
      .i_wr_en      (w_buf_wr),
      .i_wr_tag     (r_req_tag),
      .i_wr_data    (mem_rdata_i),
      .i_inv        (inv_i),
      .i_lookup_tag (w_pc_tag),
      .o_hit        (w_buf_hit),
      .o_data       (w_buf_data)
   );

   always_comb begin
      w_hit    = !rst && w_buf_hit;
      w_bypass = !rst && (r_state == WAIT) && mem_rvalid_i && (r_req_tag == w_pc_tag);
      // Every response is kept, even one for a stale pc; the tag mismatch
      // simply causes a fresh request once back in IDLE.
      w_buf_wr = !rst && (r_state == WAIT) && mem_rvalid_i;
      w_req    = !rst && (r_state == IDLE) && !w_buf_hit;

      if (w_hit) begin
         instr_o = w_buf_data;
      end else if (w_bypass) begin
         instr_o = mem_rdata_i;
      end else begin
         instr_o = NOP_INSTR;
      end
      stall_o    = !(w_hit || w_bypass);
      mem_req_o  = w_req;
      mem_addr_o = {w_pc_tag, 2'b00};
      miss_cnt_o = r_miss_cnt;
   end

   // Fetch FSM: at most one request outstanding; rvalid seen in IDLE (e.g. a
   // response to a request abandoned by reset) is ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_req_tag  <= '0;
         r_miss_cnt <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_req && mem_gnt_i) begin
                  r_req_tag  <= w_pc_tag;
                  r_miss_cnt <= r_miss_cnt + 1'b1;
                  r_state    <= WAIT;
               end
            end
            WAIT: begin
               if (mem_rvalid_i) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        inv_i;
   logic [31:0] instr_o;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] miss_cnt_o;

   int n_vec;
   int n_err;

   // Reference model: buffer contents, pending request addresses, miss count.
   bit          m_bv;
   logic [31:0] m_ba;
   logic [31:0] m_bd;
   logic [31:0] m_pend[$];
   logic [31:0] m_cnt;

   imem_fetch_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .inv_i        (inv_i),
      .instr_o      (instr_o),
      .stall_o      (stall_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .miss_cnt_o   (miss_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
      return (a >> 2) == (b >> 2);
   endfunction

   function automatic bit m_hit();
      return !rst && m_bv && same_word(m_ba, pc_i);
   endfunction

   function automatic bit m_bypass();
      return !rst && m_pend.size() != 0 && mem_rvalid_i && same_word(m_pend[0], pc_i);
   endfunction

   function automatic bit m_req();
      return !rst && m_pend.size() == 0 && !m_hit();
   endfunction

   function automatic logic [31:0] m_instr();
      if (m_hit()) return m_bd;
      if (m_bypass()) return mem_rdata_i;
      return NOP;
   endfunction

   // Advance the model by one clock edge using the inputs applied this cycle.
   task automatic model_update();
      if (rst) begin
         m_bv = 0; m_ba = 0; m_bd = 0; m_cnt = 0;
         m_pend.delete();
      end else begin
         if (m_pend.size() != 0) begin
            if (mem_rvalid_i) begin
               m_bv = 1;
               m_ba = m_pend.pop_front();
               m_bd = mem_rdata_i;
            end
         end else if (m_req() && mem_gnt_i) begin
            m_pend.push_back(pc_i & 32'hFFFF_FFFC);
            m_cnt = m_cnt + 1;
         end
         if (inv_i) m_bv = 0;
      end
   endtask

   task automatic set_in(input logic r, input logic [31:0] pc, input logic inv,
                         input logic gnt, input logic rv, input logic [31:0] rd);
      rst = r; pc_i = pc; inv_i = inv; mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      set_in(1, 32'h0, 0, 1, 1, 32'hDEAD_BEEF);
      tick();
      set_in(1, 32'h0, 0, 1, 1, 32'hDEAD_BEEF);
      n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rst_stall got=%b exp=1", stall_o); end
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", mem_req_o); end
      n_vec++; if (instr_o !== NOP) begin n_err++; $display("FAIL rst_instr got=%h exp=%h", instr_o, NOP); end
      tick();
      set_in(0, 32'h0, 0, 0, 0, 32'h0);
      n_vec++; if (miss_cnt_o !== 32'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", miss_cnt_o); end
      n_vec++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1) begin
         n_err++; $display("FAIL rst_cold got stall=%b req=%b exp stall=1 req=1", stall_o, mem_req_o);
      end
   endtask

   task automatic test_cold_miss();
      set_in(0, 32'h0, 0, 1, 0, 32'h0);
      n_vec++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
         n_err++; $display("FAIL cold_c0 got stall=%b req=%b addr=%h exp 1 1 0", stall_o, mem_req_o, mem_addr_o);
      end
      tick();
      set_in(0, 32'h0, 0, 0, 1, 32'h0050_0093);
      n_vec++; if (stall_o !== 1'b0 || instr_o !== 32'h0050_0093) begin
         n_err++; $display("FAIL cold_c1 got stall=%b instr=%h exp 0 00500093", stall_o, instr_o);
      end
      n_vec++; if (miss_cnt_o !== 32'd1) begin n_err++; $display("FAIL cold_cnt got=%0d exp=1", miss_cnt_o); end
      tick();
   endtask

   task automatic test_replay_hit();
      set_in(0, 32'h0, 0, 0, 0, 32'h1234_5678);
      n_vec++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0 || instr_o !== 32'h0050_0093) begin
         n_err++; $display("FAIL replay got stall=%b req=%b instr=%h exp 0 0 00500093", stall_o, mem_req_o, instr_o);
      end
      tick();
   endtask

   task automatic test_gnt_delay();
      logic [31:0] cnt0;
      int stalls;
      cnt0 = m_cnt;
      stalls = 0;
      for (int c = 0; c < 3; c++) begin
         set_in(0, 32'h4, 0, 0, 0, 32'h0);
         n_vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
            n_err++; $display("FAIL gdly_req c%0d got req=%b addr=%h exp 1 00000004", c, mem_req_o, mem_addr_o);
         end
         if (stall_o) stalls++;
         tick();
      end
      set_in(0, 32'h4, 0, 1, 0, 32'h0);
      if (stall_o) stalls++;
      tick();
      set_in(0, 32'h4, 0, 0, 0, 32'h0);
      if (stall_o) stalls++;
      n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL gdly_wait_req got=%b exp=0", mem_req_o); end
      tick();
      set_in(0, 32'h4, 0, 0, 1, 32'h0010_0113);
      n_vec++; if (stall_o !== 1'b0 || instr_o !== 32'h0010_0113) begin
         n_err++; $display("FAIL gdly_byp got stall=%b instr=%h exp 0 00100113", stall_o, instr_o);
      end
      n_vec++; if (stalls != 5) begin n_err++; $display("FAIL gdly_stalls got=%0d exp=5", stalls); end
      n_vec++; if (miss_cnt_o !== cnt0 + 32'd1) begin
         n_err++; $display("FAIL gdly_cnt got=%0d exp=%0d", miss_cnt_o, cnt0 + 1);
      end
      tick();
   endtask

   task automatic test_redirect();
      set_in(0, 32'h8, 0, 1, 0, 32'h0);
      tick();
      set_in(0, 32'h40, 0, 0, 1, 32'h0000_8888);
      n_vec++; if (stall_o !== 1'b1 || instr_o !== NOP || mem_req_o !== 1'b0) begin
         n_err++; $display("FAIL redir_nobyp got stall=%b instr=%h req=%b exp 1 %h 0", stall_o, instr_o, mem_req_o, NOP);
      end
      tick();
      set_in(0, 32'h40, 0, 0, 0, 32'h0);
      n_vec++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40 || stall_o !== 1'b1) begin
         n_err++; $display("FAIL redir_newreq got req=%b addr=%h stall=%b exp 1 00000040 1", mem_req_o, mem_addr_o, stall_o);
      end
      set_in(0, 32'h8, 0, 0, 0, 32'h0);
      n_vec++; if (stall_o !== 1'b0 || instr_o !== 32'h0000_8888) begin
         n_err++; $display("FAIL redir_buf got stall=%b instr=%h exp 0 00008888", stall_o, instr_o);
      end
      tick();
   endtask

   task automatic test_invalidate();
      set_in(0, 32'h0, 0, 1, 0, 32'h0);
      tick();
      set_in(0, 32'h0, 0, 0, 1, 32'h0050_0093);
      tick();
      set_in(0, 32'h0, 1, 0, 0, 32'h0);
      n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL inv_same_cycle got stall=%b exp=0", stall_o); end
      tick();
      set_in(0, 32'h0, 0, 0, 0, 32'h0);
      n_vec++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1) begin
         n_err++; $display("FAIL inv_next got stall=%b req=%b exp 1 1", stall_o, mem_req_o);
      end
      // Invalidate coinciding with the fill: bypass still serves this cycle.
      set_in(0, 32'h0, 0, 1, 0, 32'h0);
      tick();
      set_in(0, 32'h0, 1, 0, 1, 32'h0AAA_0013);
      n_vec++; if (stall_o !== 1'b0 || instr_o !== 32'h0AAA_0013) begin
         n_err++; $display("FAIL inv_fill_byp got stall=%b instr=%h exp 0 0aaa0013", stall_o, instr_o);
      end
      tick();
      set_in(0, 32'h0, 0, 0, 0, 32'h0);
      n_vec++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1) begin
         n_err++; $display("FAIL inv_fill_after got stall=%b req=%b exp 1 1", stall_o, mem_req_o);
      end
   endtask

   task automatic test_reset_mid_wait();
      set_in(0, 32'h10, 0, 1, 0, 32'h0);
      tick();
      set_in(1, 32'h10, 0, 0, 0, 32'h0);
      tick();
      set_in(0, 32'h10, 0, 0, 1, 32'h0BAD_0013);
      n_vec++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1 || miss_cnt_o !== 32'd0) begin
         n_err++; $display("FAIL rstw_late got stall=%b req=%b cnt=%0d exp 1 1 0", stall_o, mem_req_o, miss_cnt_o);
      end
      tick();
      set_in(0, 32'h10, 0, 0, 0, 32'h0);
      n_vec++; if (stall_o !== 1'b1 || mem_req_o !== 1'b1) begin
         n_err++; $display("FAIL rstw_buf got stall=%b req=%b exp 1 1", stall_o, mem_req_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] pcs[6];
      logic [31:0] pc;
      logic [31:0] ei;
      bit          es, er;
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
      pcs[3] = 32'h40; pcs[4] = 32'h1000; pcs[5] = 32'hFFFF_FFFC;
      pc = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         if (!stall_o || $urandom_range(0, 9) == 0)
            pc = pcs[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
         set_in(($urandom_range(0, 199) == 0), pc, ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1), $urandom);
         es = !(m_hit() || m_bypass());
         ei = m_instr();
         er = m_req();
         n_vec++; if (stall_o !== es || instr_o !== ei) begin
            n_err++; $display("FAIL rnd_out i=%0d got stall=%b instr=%h exp %b %h", i, stall_o, instr_o, es, ei);
         end
         n_vec++; if (mem_req_o !== er || (er && mem_addr_o !== (pc & 32'hFFFF_FFFC))) begin
            n_err++; $display("FAIL rnd_req i=%0d got req=%b addr=%h exp %b %h", i, mem_req_o, mem_addr_o, er, pc & 32'hFFFF_FFFC);
         end
         n_vec++; if (miss_cnt_o !== m_cnt) begin
            n_err++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, miss_cnt_o, m_cnt);
         end
         tick();
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_bv = 0; m_ba = 0; m_bd = 0; m_cnt = 0;
      rst = 1; pc_i = 0; inv_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      @(negedge clk);
      test_reset();
      test_cold_miss();
      test_replay_hit();
      test_gnt_delay();
      test_redirect();
      test_invalidate();
      test_reset_mid_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 pc_i  input  32  fetch address from the fetch PC register, held stable by the fetch stage while stall_o=1.
REQ-005 inv_i  input  1  invalidates the fetch buffer (fence.i).
REQ-006 instr_o  output  32  instruction word for pc_i; valid when stall_o=0.
REQ-007 stall_o  output  1  fetch stall; drives the fetch stage stall input.
REQ-008 mem_req_o  output  1  bus request.
REQ-009 mem_addr_o  output  32  bus word address.
REQ-010 mem_gnt_i  input  1  request accepted in the current cycle.
REQ-011 mem_rvalid_i  input  1  read data valid.
REQ-012 mem_rdata_i  input  32  read data.
REQ-013 miss_cnt_o  output  32  count of accepted bus requests.

Function
REQ-014 The block SHALL hold a one-entry fetch buffer {buf_valid, buf_addr[31:0], buf_data[31:0]}.
REQ-015 Hit: buf_valid=1 and buf_addr==pc_i; the block SHALL drive stall_o=0 and instr_o=buf_data in the same cycle.
REQ-016 Bypass: state WAIT, mem_rvalid_i=1 and req_addr==pc_i; the block SHALL drive stall_o=0 and instr_o=mem_rdata_i in the same cycle.
REQ-017 In all other cases the block SHALL drive stall_o=1 and instr_o=32'h00000013 (NOP).
REQ-018 FSM states SHALL be IDLE and WAIT, with one outstanding request maximum.
REQ-019 IDLE with no hit: mem_req_o=1 and mem_addr_o={pc_i[31:2],2'b00}, combinationally.
REQ-020 IDLE with mem_gnt_i=1: latch req_addr=mem_addr_o, increment miss_cnt_o, go to WAIT.
REQ-021 WAIT: mem_req_o=0; on mem_rvalid_i, write buffer {1, req_addr, mem_rdata_i} and go to IDLE.
REQ-022 A response whose req_addr no longer matches pc_i SHALL still be written to the buffer; the tag mismatch forces a new request on the next IDLE cycle.
REQ-023 mem_rvalid_i in IDLE SHALL be ignored.
REQ-024 inv_i SHALL clear buf_valid on the next edge.
REQ-025 inv_i and a buffer write on the same edge: invalidate wins, and the bypass still applies in that cycle.
REQ-026 Tag comparison SHALL use pc_i[31:2].
REQ-027 miss_cnt_o SHALL wrap from 32'hFFFFFFFF to 0.
REQ-028 Minimum miss penalty SHALL be one stall cycle: gnt in cycle 0, rvalid plus bypass in cycle 1.

Reset
REQ-029 On rst: state=IDLE, buf_valid=0, buf_addr=0, buf_data=0, req_addr=0, miss_cnt_o=0.
REQ-030 While rst=1, mem_req_o SHALL be 0 and stall_o SHALL be 1.
REQ-031 Reset during WAIT SHALL abandon the request; a late rvalid arrives in IDLE and is ignored per REQ-023.

Structure
REQ-032 Package imem_pkg SHALL hold XLEN=32, NOP_INSTR=32'h00000013, and enum fetch_state_t {IDLE, WAIT}.
REQ-033 Sub-module fetch_buf SHALL hold the tag/data/valid register with hit compare; the FSM and counter live in the top module.

Verification
REQ-034 Cold miss: reset, pc_i=0x0, gnt in cycle 0, rvalid with 0x00500093 in cycle 1 -> stall_o=1 in cycle 0, stall_o=0 and instr_o=0x00500093 in cycle 1, miss_cnt_o=1.
REQ-035 Replay hit: pc_i=0x0 held after REQ-034 -> stall_o=0, mem_req_o=0, instr_o=0x00500093.
REQ-036 Gnt delay: pc_i=0x4, gnt withheld for 3 cycles, rvalid 2 cycles after gnt -> mem_req_o=1 and mem_addr_o=0x4 held for 3 cycles, stall_o=1 for 5 cycles, miss_cnt_o increments by exactly 1.
REQ-037 Redirect during WAIT: request for 0x8 outstanding, pc_i changes to 0x40 -> 0x8 data written to buffer, no bypass, new request for 0x40 issued the next cycle.
REQ-038 Invalidate: buffer holds 0x0, inv_i pulsed -> next cycle pc_i=0x0 gives stall_o=1 and mem_req_o=1.
REQ-039 Reset mid-WAIT: rst during WAIT, then rvalid after reset -> buffer unchanged (buf_valid=0), state IDLE, miss_cnt_o=0.
